// File: rtl/gnt_sample_if_if.sv
// Grant-bus sampling interface: producer-side grant plus all sampled views.
`timescale 1ns/1ps
interface gnt_sample_if_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] gnt;
  logic [WIDTH-1:0] gnt_s0;
  logic [WIDTH-1:0] gnt_s1;
  logic [WIDTH-1:0] gnt_s1_prev;
  logic             s1_valid;
  logic             s1_changed;
  logic             s1_zero;
  logic [CNT_W-1:0] sample_cnt;

  // Producer / consumer side: drives the live bus, observes the views.
  modport master (
    output gnt,
    input  gnt_s0, gnt_s1, gnt_s1_prev, s1_valid, s1_changed, s1_zero, sample_cnt
  );

  // Sampler side.
  modport slave (
    input  gnt,
    output gnt_s0, gnt_s1, gnt_s1_prev, s1_valid, s1_changed, s1_zero, sample_cnt
  );
endinterface

// File: rtl/gnt_sample_if.sv
// Grant-bus sampling front-end: zero-skew view, pre-edge registered view,
// previous-sample history, valid/change/zero flags and a wrapping edge counter.
`timescale 1ns/1ps
module gnt_sample_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  gnt_sample_if_if.slave bus
);

  logic [WIDTH-1:0] gnt_s1_q,      gnt_s1_d;
  logic [WIDTH-1:0] gnt_s1_prev_q, gnt_s1_prev_d;
  logic             s1_valid_q,    s1_valid_d;
  logic             s1_changed_q,  s1_changed_d;
  logic [CNT_W-1:0] sample_cnt_q,  sample_cnt_d;

  // Zero-skew view is a wire; it is deliberately outside reset.
  assign bus.gnt_s0 = bus.gnt;

  // Next-state: every edge out of reset is a sample. Change detect compares
  // against the sample currently held, and only once one has been captured,
  // so the first sample after reset never flags a change.
  always_comb begin
    gnt_s1_d      = bus.gnt;
    gnt_s1_prev_d = gnt_s1_q;
    s1_valid_d    = 1'b1;
    s1_changed_d  = s1_valid_q && (bus.gnt != gnt_s1_q);
    sample_cnt_d  = sample_cnt_q + CNT_W'(1);
  end

  // Sample registers; async reset clears all history immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_s1_q      <= '0;
      gnt_s1_prev_q <= '0;
      s1_valid_q    <= 1'b0;
      s1_changed_q  <= 1'b0;
      sample_cnt_q  <= '0;
    end else begin
      gnt_s1_q      <= gnt_s1_d;
      gnt_s1_prev_q <= gnt_s1_prev_d;
      s1_valid_q    <= s1_valid_d;
      s1_changed_q  <= s1_changed_d;
      sample_cnt_q  <= sample_cnt_d;
    end
  end

  assign bus.gnt_s1      = gnt_s1_q;
  assign bus.gnt_s1_prev = gnt_s1_prev_q;
  assign bus.s1_valid    = s1_valid_q;
  assign bus.s1_changed  = s1_changed_q;
  // Zero flag is qualified so a cleared register after reset does not read as a zero grant.
  assign bus.s1_zero     = s1_valid_q && (gnt_s1_q == '0);
  assign bus.sample_cnt  = sample_cnt_q;

endmodule

// File: tb/tb_gnt_sample_if.sv
// Randomized bench for gnt_sample_if against a sample-history reference model.
`timescale 1ns/1ps
module tb_gnt_sample_if;

  logic       clk;
  logic       rst_n;
  logic [3:0] gnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: history of captured pre-edge samples since reset.
  logic [3:0] hist[$];
  int unsigned nsamp;

  gnt_sample_if_if #(.WIDTH(4), .CNT_W(16)) bus  ();
  gnt_sample_if_if #(.WIDTH(4), .CNT_W(4))  bus4 ();

  assign bus.gnt  = gnt;
  assign bus4.gnt = gnt;

  gnt_sample_if #(.WIDTH(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  gnt_sample_if #(.WIDTH(4), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    nsamp = 0;
  endtask

  task automatic model_push(input logic [3:0] v);
    hist.push_back(v);
    if (hist.size() > 2) void'(hist.pop_front());
    nsamp++;
  endtask

  task automatic check_all(input string ph);
    logic [3:0] es1, ep;
    logic       ev, ec, ez;
    ev  = (hist.size() > 0);
    es1 = ev ? hist[hist.size()-1] : 4'h0;
    ep  = (hist.size() > 1) ? hist[hist.size()-2] : 4'h0;
    ec  = (hist.size() > 1) && (hist[hist.size()-1] != hist[hist.size()-2]);
    ez  = ev && (es1 == 4'h0);
    chk({ph, ".s1"},      bus.gnt_s1,      es1);
    chk({ph, ".prev"},    bus.gnt_s1_prev, ep);
    chk({ph, ".valid"},   bus.s1_valid,    ev);
    chk({ph, ".changed"}, bus.s1_changed,  ec);
    chk({ph, ".zero"},    bus.s1_zero,     ez);
    chk({ph, ".cnt"},     bus.sample_cnt,  nsamp % 65536);
    chk({ph, ".cnt4"},    bus4.sample_cnt, nsamp % 16);
    chk({ph, ".s0"},      bus.gnt_s0,      gnt);
  endtask

  // Starts and ends at a falling edge; holds v across the rising edge.
  task automatic step(input logic [3:0] v, input string ph);
    gnt = v;
    @(posedge clk);
    model_push(v);
    #1 check_all(ph);
    @(negedge clk);
  endtask

  // Producer toggles the bus every 1 ns; only the last pre-edge value counts.
  task automatic step_busy(input string ph);
    logic [3:0] v;
    for (int i = 0; i < 5; i++) begin
      v   = 4'($urandom_range(0, 15));
      gnt = v;
      #0.5 chk({ph, ".s0live"}, bus.gnt_s0, v);
      if (i < 4) #0.5;
    end
    @(posedge clk);
    model_push(v);
    #1 check_all(ph);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] v;
    rst_n = 1'b0;
    gnt   = 4'h3;
    model_reset();
    #2 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Steady 3 over three edges.
    for (int i = 0; i < 3; i++) step(4'h3, "steady");
    chk("steady.cnt3", bus.sample_cnt, 3);

    // Producer moves 5 -> A exactly at the edge, as a clocked producer would.
    gnt = 4'h5;
    @(posedge clk);
    gnt <= 4'hA;
    model_push(4'h5);
    #1;
    chk("edge.s1", bus.gnt_s1, 4'h5);
    chk("edge.s0", bus.gnt_s0, 4'hA);
    check_all("edge");
    @(negedge clk);
    step(4'hA, "edge2");

    // 1,1,2 change sequence.
    step(4'h1, "seq1");
    step(4'h1, "seq2");
    step(4'h2, "seq3");
    chk("seq.prev", bus.gnt_s1_prev, 4'h1);
    chk("seq.chg",  bus.s1_changed,  1'b1);

    // Async reset mid-cycle with 7 held.
    step(4'h7, "pre_rst");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    chk("async_rst.s1", bus.gnt_s1, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'h7, "post_rst");
    chk("post_rst.chg", bus.s1_changed, 1'b0);

    // Counter wrap on the narrow-counter instance after a fresh reset.
    rst_n = 1'b0;
    model_reset();
    #1 check_all("wrap_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) step(4'($urandom_range(0, 15)), "wrap");
    chk("wrap.cnt4", bus4.sample_cnt, 0);
    chk("wrap.cnt16", bus.sample_cnt, 16);

    // Randomized: busy producer, and sparse values with frequent repeats/zeros.
    for (int i = 0; i < 100; i++) step_busy("busy");
    v = 4'h0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) != 0) v = 4'($urandom_range(0, 3));
      step(v, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
